vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Consumes the horizontal and vertical position counts produced by the pixel-rate `Counter` instances and turns them into registered VGA timing: hsync, vsync, active-video, pixel coordinates and line/frame strobes. Sits between the h/v counter pair and the pixel pipeline/output pins. Also checks that the incoming counts follow the legal raster sequence. Phase tracking uses one FSM per axis.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `WIDTH`, 10, width of the count inputs and coordinate outputs
- `SYNC_POL`, 0, asserted level of hsync/vsync (0 = active-low)
- `clk`  in  1  pixel-domain clock
- `rst`  in  1  asynchronous, active-low reset
- `clk_en`  in  1  pixel tick; all state advances only when high
- `h_count`  in  WIDTH  horizontal position, 0..H_TOTAL-1
- `v_count`  in  WIDTH  vertical position, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, polarity per SYNC_POL
- `vsync`  out  1  vertical sync, polarity per SYNC_POL
- `active`  out  1  high while both axes are in the ACTIVE phase
- `x`  out  WIDTH  h_count when active, else 0
- `y`  out  WIDTH  v_count when active, else 0
- `line_start`  out  1  one-cycle pulse when h_count = 0 is sampled
- `frame_start`  out  1  one-cycle pulse when h_count = 0 and v_count = 0 are sampled
- `seq_err`  out  1  sticky raster-sequence error (checker builds only)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). All compares are unsigned WIDTH-bit. Parameter sets with H_TOTAL or V_TOTAL > 2^WIDTH are illegal.
- Phase FSM per axis: states ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - The next state is decoded from the sampled count: [0, A) ACTIVE, [A, A+FP) FRONT, [A+FP, A+FP+S) SYNC, [A+FP+S, TOTAL) BACK.
  - The vertical FSM updates only on ticks where h_count = 0.
- hsync asserted iff the H phase is SYNC; vsync asserted iff the V phase is SYNC. Deasserted level = !SYNC_POL.
- Counts ≥ TOTAL decode as BACK. x and y hold 0 in that case.
- Reset: hsync = vsync = !SYNC_POL; active, line_start, frame_start, seq_err = 0; x = y = 0; both FSMs in BACK.
- Reset assertion mid-frame forces the reset values on the next observable edge (asynchronous). After release, the first clk_en re-decodes directly from the counts; no resynchronisation frame is needed.

## Timing
- Latency: exactly one clk edge from a clk_en-qualified sample to every output.
- With clk_en low, all outputs hold except `line_start` and `frame_start`, which are single-clk pulses and clear on the next edge.
- Wrap: after h_count = 799, h_count = 0 is sampled and produces `line_start`. After (799, 524), (0, 0) is sampled and produces both strobes on the same edge.
- Boundaries:
  - h_count = 639: active = 1, x = 639.
  - h_count = 640: active = 0.
  - h_count = 656: hsync asserts.
  - h_count = 752: hsync deasserts.

## Configuration
- `VGA_SYNC_CHECK_EN` defined: the sequence checker is compiled in. On each clk_en after the first post-reset tick:
  - The expected h value is prev_h+1, or 0 after H_TOTAL-1.
  - The expected v value is unchanged, except prev_v+1 (or 0 after V_TOTAL-1) when h wraps.
  - Any mismatch sets `seq_err` one edge later. `seq_err` is cleared only by reset.
- Not defined: no checker logic is built and `seq_err` is tied to 0.

## Structure
- Shared package `vga_timing_pkg`:
  - phase typedef `vga_phase_t` (ACTIVE, FRONT, SYNC, BACK)
  - 640x480@60 default constants
  - H_TOTAL/V_TOTAL derivation function
- Sub-module `vga_phase_fsm`: parameterised by active/fp/sync/bp/width, inputs count and advance enable, output phase. Instantiated twice (H and V).

## Test plan
- Reset held low with clk_en toggling → hsync = vsync = 1, active = 0, x = y = 0, seq_err = 0.
- Free-running 800x525 counts → hsync low for exactly 96 ticks starting at sample h = 656; vsync low for 2 lines starting at v = 490; 307200 active ticks per frame.
- Sample (799, 524) then (0, 0) → line_start and frame_start both high for one clk; active = 1, x = 0, y = 0.
- clk_en held low for 20 cycles during h = 700 → outputs frozen, no strobes, no seq_err.
- With `VGA_SYNC_CHECK_EN`, inject h jump 100 → 102 → seq_err = 1 one edge later, stays set until rst low.
- rst pulsed low at (320, 200) → outputs return to reset values immediately; the first tick after release at (330, 200) gives active = 1, x = 330, and no seq_err.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster types and 640x480@60 timing constants.
// Combinational helpers only; no latency, no backpressure.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } vga_phase_t;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_WIDTH    = 10;

    function automatic int unsigned vga_total(input int unsigned act_len,
                                              input int unsigned fp_len,
                                              input int unsigned sync_len,
                                              input int unsigned bp_len);
        return act_len + fp_len + sync_len + bp_len;
    endfunction

endpackage

// File: rtl/vga_phase_fsm.sv
// One-axis raster phase tracker: decodes count into ACTIVE/FRONT/SYNC/BACK.
// Phase is valid one clk edge after an advance-qualified sample; no backpressure.
module vga_phase_fsm
    import vga_timing_pkg::*;
#(
    parameter int unsigned N_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned N_FP     = VGA_H_FP,
    parameter int unsigned N_SYNC   = VGA_H_SYNC,
    parameter int unsigned N_BP     = VGA_H_BP,
    parameter int unsigned WIDTH    = VGA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic [WIDTH-1:0] count,
    output vga_phase_t       phase
);

    // One extra bit so a boundary equal to 2^WIDTH still compares correctly.
    localparam logic [WIDTH:0] FRONT_AT = (WIDTH+1)'(N_ACTIVE);
    localparam logic [WIDTH:0] SYNC_AT  = (WIDTH+1)'(N_ACTIVE + N_FP);
    localparam logic [WIDTH:0] BACK_AT  = (WIDTH+1)'(N_ACTIVE + N_FP + N_SYNC);

    logic [WIDTH:0] cnt_ext;
    vga_phase_t     phase_next;

    assign cnt_ext = {1'b0, count};

    always_comb begin
        phase_next = phase;
        if (advance) begin
            // Back porch also absorbs out-of-range counts.
            phase_next = BACK;
            if (cnt_ext < FRONT_AT) begin
                phase_next = ACTIVE;
            end else if (cnt_ext < SYNC_AT) begin
                phase_next = FRONT;
            end else if (cnt_ext < BACK_AT) begin
                phase_next = SYNC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= BACK;
        end else begin
            phase <= phase_next;
        end
    end

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA timing decoder (hsync/vsync/active/x/y/strobes); one clk edge latency, clk_en-paced, no backpressure.
// Define VGA_SYNC_CHECK_EN to build the sticky raster-sequence checker driving seq_err.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned WIDTH    = VGA_WIDTH,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] h_count,
    input  logic [WIDTH-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic             seq_err
);

    vga_phase_t       h_phase;
    vga_phase_t       v_phase;
    logic             primed;
    logic             h_zero;
    logic             v_adv;
    logic [WIDTH-1:0] h_q;
    logic [WIDTH-1:0] v_q;

    assign h_zero = (h_count == '0);
    // The first tick after reset re-decodes V directly instead of waiting for a line wrap.
    assign v_adv  = clk_en && (h_zero || !primed);

    vga_phase_fsm #(
        .N_ACTIVE (H_ACTIVE),
        .N_FP     (H_FP),
        .N_SYNC   (H_SYNC),
        .N_BP     (H_BP),
        .WIDTH    (WIDTH)
    ) u_h_fsm (
        .clk     (clk),
        .rst     (rst),
        .advance (clk_en),
        .count   (h_count),
        .phase   (h_phase)
    );

    vga_phase_fsm #(
        .N_ACTIVE (V_ACTIVE),
        .N_FP     (V_FP),
        .N_SYNC   (V_SYNC),
        .N_BP     (V_BP),
        .WIDTH    (WIDTH)
    ) u_v_fsm (
        .clk     (clk),
        .rst     (rst),
        .advance (v_adv),
        .count   (v_count),
        .phase   (v_phase)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            primed      <= 1'b0;
            h_q         <= '0;
            v_q         <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (clk_en) begin
                primed      <= 1'b1;
                h_q         <= h_count;
                v_q         <= v_count;
                line_start  <= h_zero;
                frame_start <= h_zero && (v_count == '0);
            end
        end
    end

    assign hsync  = (h_phase == SYNC) ? SYNC_POL : !SYNC_POL;
    assign vsync  = (v_phase == SYNC) ? SYNC_POL : !SYNC_POL;
    assign active = (h_phase == ACTIVE) && (v_phase == ACTIVE);
    assign x      = active ? h_q : '0;
    assign y      = active ? v_q : '0;

`ifdef VGA_SYNC_CHECK_EN
    localparam int unsigned    H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned    V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [WIDTH-1:0] H_LAST = WIDTH'(H_TOTAL - 1);
    localparam logic [WIDTH-1:0] V_LAST = WIDTH'(V_TOTAL - 1);

    logic             err_q;
    logic             h_wrap;
    logic [WIDTH-1:0] exp_h;
    logic [WIDTH-1:0] exp_v;

    // h_q/v_q hold the previous qualified sample, which is what the raster must follow.
    always_comb begin
        h_wrap = (h_q == H_LAST);
        exp_h  = h_wrap ? '0 : h_q + 1'b1;
        exp_v  = v_q;
        if (h_wrap) begin
            exp_v = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (clk_en && primed && ((h_count != exp_h) || (v_count != exp_v))) begin
            err_q <= 1'b1;
        end
    end

    assign seq_err = err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed self-checking bench for vga_sync_decoder at 640x480 default timing.
module tb_vga_sync_decoder;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;
    logic       seq_err;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef VGA_SYNC_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    vga_sync_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .h_count     (h_count),
        .v_count     (v_count),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int h, input int v);
        @(negedge clk);
        clk_en  = 1'b1;
        h_count = 10'(h);
        v_count = 10'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        clk_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int n_act, n_hlow, n_vlow, n_ls, n_fs;
        rst     = 1'b0;
        clk_en  = 1'b0;
        h_count = 10'd656;
        v_count = 10'd490;

        // Reset held with clk_en toggling on counts that would decode as SYNC
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clk_en = ~clk_en;
        end
        @(posedge clk);
        #1;
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_active", active, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_line_start", line_start, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_seq_err", seq_err, 0);

        // Free-running lines 478..492 covering end of active area and vsync
        @(negedge clk);
        rst = 1'b1;
        n_act = 0; n_hlow = 0; n_vlow = 0; n_ls = 0; n_fs = 0;
        for (int v = 478; v <= 492; v++) begin
            for (int h = 0; h < 800; h++) begin
                step(h, v);
                n_act  += int'(active);
                n_hlow += int'(!hsync);
                n_vlow += int'(!vsync);
                n_ls   += int'(line_start);
                n_fs   += int'(frame_start);
                if (v == 478 && h == 655) chk("hsync_655", hsync, 1);
                if (v == 478 && h == 656) chk("hsync_656", hsync, 0);
                if (v == 478 && h == 751) chk("hsync_751", hsync, 0);
                if (v == 478 && h == 752) chk("hsync_752", hsync, 1);
                if (v == 479 && h == 5)   chk("y_479", y, 479);
                if (v == 479 && h == 639) begin
                    chk("active_639", active, 1);
                    chk("x_639", x, 639);
                end
                if (v == 479 && h == 640) begin
                    chk("active_640", active, 0);
                    chk("x_640", x, 0);
                end
                if (v == 480 && h == 0)   chk("active_v480", active, 0);
                if (v == 489 && h == 799) chk("vsync_489", vsync, 1);
                if (v == 490 && h == 0)   chk("vsync_490", vsync, 0);
                if (v == 491 && h == 799) chk("vsync_491", vsync, 0);
                if (v == 492 && h == 0)   chk("vsync_492", vsync, 1);
            end
        end
        chk("active_ticks", n_act, 1280);
        chk("hsync_low_ticks", n_hlow, 1440);
        chk("vsync_low_ticks", n_vlow, 1600);
        chk("line_start_count", n_ls, 15);
        chk("frame_start_count", n_fs, 0);
        chk("run_seq_err", seq_err, 0);

        // Frame wrap
        rst_pulse();
        step(798, 524);
        step(799, 524);
        chk("wrap_pre_active", active, 0);
        chk("wrap_pre_vsync", vsync, 1);
        chk("wrap_pre_ls", line_start, 0);
        step(0, 0);
        chk("wrap_ls", line_start, 1);
        chk("wrap_fs", frame_start, 1);
        chk("wrap_active", active, 1);
        chk("wrap_x", x, 0);
        chk("wrap_y", y, 0);
        idle();
        chk("wrap_ls_clear", line_start, 0);
        chk("wrap_fs_clear", frame_start, 0);
        chk("wrap_active_hold", active, 1);

        // clk_en low for 20 cycles at h = 700
        for (int h = 1; h <= 700; h++) step(h, 0);
        chk("h700_hsync", hsync, 0);
        chk("h700_active", active, 0);
        for (int i = 0; i < 20; i++) begin
            idle();
            chk("freeze_hsync", hsync, 0);
            chk("freeze_active", active, 0);
            chk("freeze_ls", line_start, 0);
        end
        step(701, 0);
        chk("unfreeze_seq_err", seq_err, 0);
        chk("unfreeze_hsync", hsync, 0);

        // Asynchronous reset mid-frame, then direct re-decode
        rst_pulse();
        step(318, 200);
        step(319, 200);
        step(320, 200);
        chk("pre_rst_active", active, 1);
        chk("pre_rst_x", x, 320);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_active", active, 0);
        chk("async_rst_x", x, 0);
        chk("async_rst_y", y, 0);
        chk("async_rst_hsync", hsync, 1);
        @(negedge clk);
        rst = 1'b1;
        step(330, 200);
        chk("post_rst_active", active, 1);
        chk("post_rst_x", x, 330);
        chk("post_rst_y", y, 200);
        chk("post_rst_seq_err", seq_err, 0);

        // Sequence error injection 100 -> 102
        rst_pulse();
        step(99, 200);
        step(100, 200);
        chk("seq_ok", seq_err, 0);
        step(102, 200);
        chk("seq_jump", seq_err, EXP_ERR);
        idle();
        idle();
        chk("seq_sticky_idle", seq_err, EXP_ERR);
        step(103, 200);
        chk("seq_sticky_legal", seq_err, EXP_ERR);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("seq_cleared", seq_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
